serial_sub: RTL

- Bit-serial N-bit subtractor: the inverse operation of the team's full adder, built around one full-subtractor cell and a registered borrow.
- Computes DIFF = A - B - B_in, LSB first, one bit per clock.
- Used where area matters more than latency; serves as the sequential counterpart to the combinational adder chain.

---
 rtl/serial_sub.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/serial_sub.sv
// -----------------------------------------------------------------------------
// serial_sub -- bit-serial N-bit subtractor, DIFF = A - B - B_in, LSB first.
//
// A single full-subtractor cell is shared across all bit positions. The borrow
// is held in a register between clock cycles. One bit is processed per clock.
// Trading latency for area makes this the sequential counterpart of the
// combinational adder chain.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2)
//
// Ports:
//   CLK    in   clock, rising-edge
//   RST    in   asynchronous, active-high reset
//   START  in   request. It is sampled only in IDLE.
//   A      in   minuend. It is latched on an accepted START.
//   B      in   subtrahend. It is latched on an accepted START.
//   B_in   in   borrow-in. It is latched on an accepted START.
//   BUSY   out  high while the bits are being processed (WIDTH cycles)
//   DONE   out  one-cycle completion pulse
//   DIFF   out  result. It holds until the next completion.
//   B_out  out  final borrow-out. It holds with DIFF.
//   OVF    out  signed overflow. This port exists only with SERIAL_SUB_OVF_EN.
//
// Optional feature macro: SERIAL_SUB_OVF_EN
//   When this macro is defined, the OVF port is added. OVF is the two's-complement
//   overflow of the latched operands. It is updated together with DIFF.
// -----------------------------------------------------------------------------
module serial_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_in,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             B_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    count;

`ifdef SERIAL_SUB_OVF_EN
  // The operand sign bits are shifted out of sa/sb, so they are kept here for the overflow term.
  logic             a_msb;
  logic             b_msb;
`endif

  // Full-subtractor cell acting on the current LSBs and the stored borrow.
  logic a_bit;
  logic b_bit;
  logic d_bit;
  logic br_nxt;
  logic last_bit;

  always_comb begin
    a_bit    = sa[0];
    b_bit    = sb[0];
    d_bit    = a_bit ^ b_bit ^ br;
    br_nxt   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    last_bit = (count == CW'(WIDTH - 1));
  end

  // Control FSM and datapath. Every output is registered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      DIFF  <= '0;
      B_out <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      br    <= 1'b0;
      count <= '0;
`ifdef SERIAL_SUB_OVF_EN
      OVF   <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            sa    <= A;
            sb    <= B;
            br    <= B_in;
            res   <= '0;
            count <= '0;
            BUSY  <= 1'b1;
            state <= RUN;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
`endif
          end
        end

        RUN: begin
          // Each result bit enters at the MSB. After WIDTH shifts, bit 0 has reached position 0.
          res   <= {d_bit, res[WIDTH-1:1]};
          sa    <= {1'b0, sa[WIDTH-1:1]};
          sb    <= {1'b0, sb[WIDTH-1:1]};
          br    <= br_nxt;
          count <= count + CW'(1);
          if (last_bit) begin
            // Publish on the final edge so that DIFF and B_out are valid while DONE is high.
            DIFF  <= {d_bit, res[WIDTH-1:1]};
            B_out <= br_nxt;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= FIN;
`ifdef SERIAL_SUB_OVF_EN
            // d_bit is the sign bit of the final difference.
            OVF   <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
          end
        end

        FIN: begin
          DONE  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
